// File: rtl/sum_req_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared-adder arbiter
// and the result consumer. The arbiter takes the slave side.
interface sum_req_arbiter_if #(
  parameter int WIDTH = 8
) ();

  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_id;
  logic             res_ready;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_carry, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_carry, res_id
  );

endinterface

// File: rtl/sum_req_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between two requesters.
// One transaction in flight: IDLE grants, CALC adds, DONE holds the result.
module sum_req_arbiter #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  sum_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             prio_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;

  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_carry_q;
  logic             res_id_q;

  logic             grant_vld_d;
  logic             grant_id_d;
  logic [WIDTH-1:0] sel_a_d;
  logic [WIDTH-1:0] sel_b_d;
  logic [WIDTH:0]   sum_d;

  // Winner selection; only offered in IDLE and never while reset is applied.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld_d = 1'b1;
        grant_id_d  = prio_q;
      end else if (bus.req0_valid) begin
        grant_vld_d = 1'b1;
        grant_id_d  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld_d = 1'b1;
        grant_id_d  = 1'b1;
      end else begin
        grant_vld_d = 1'b0;
        grant_id_d  = 1'b0;
      end
    end else begin
      grant_vld_d = 1'b0;
      grant_id_d  = 1'b0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_d = bus.req0_a;
    sel_b_d = bus.req0_b;
    if (grant_id_d) begin
      sel_a_d = bus.req1_a;
      sel_b_d = bus.req1_b;
    end else begin
      sel_a_d = bus.req0_a;
      sel_b_d = bus.req0_b;
    end
  end

  assign sum_d = {1'b0, a_q} + {1'b0, b_q};

  assign bus.req0_ready = grant_vld_d & ~grant_id_d;
  assign bus.req1_ready = grant_vld_d &  grant_id_d;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.res_id     = res_id_q;

  // Transaction sequencer with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            a_q     <= sel_a_d;
            b_q     <= sel_b_d;
            id_q    <= grant_id_d;
            // Loser of this grant wins the next contended cycle.
            prio_q  <= ~grant_id_d;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          res_data_q  <= sum_d[WIDTH-1:0];
          res_carry_q <= sum_d[WIDTH];
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q     <= DONE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_req_arbiter.sv
// Randomized bench for sum_req_arbiter against a transaction-level model of
// the grant, latency and result rules.
module tb_sum_req_arbiter;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  sum_req_arbiter_if #(.WIDTH(WIDTH)) bus ();

  sum_req_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: outstanding transaction, edges since it was accepted,
  // round-robin priority and the expected result.
  bit m_busy;
  int m_age;
  bit m_prio;
  int m_sum;
  bit m_id;
  bit m_after_rst;
  int acc0;
  int acc1;
  bit w_vld;
  bit w_id;

  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check_eq("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
      m_busy      = 1'b0;
      m_age       = 0;
      m_prio      = 1'b0;
      m_after_rst = 1'b1;
    end else begin
      if (m_after_rst) begin
        check_eq("reset_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check_eq("reset_res_data",  {24'd0, bus.res_data}, 32'd0);
        check_eq("reset_res_carry", {31'd0, bus.res_carry}, 32'd0);
        check_eq("reset_res_id",    {31'd0, bus.res_id}, 32'd0);
        m_after_rst = 1'b0;
      end
      w_vld = !m_busy && (bus.req0_valid || bus.req1_valid);
      w_id  = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
      check_eq("req0_ready", {31'd0, bus.req0_ready}, {31'd0, w_vld && !w_id});
      check_eq("req1_ready", {31'd0, bus.req1_ready}, {31'd0, w_vld && w_id});
      check_eq("res_valid", {31'd0, bus.res_valid}, {31'd0, m_busy && m_age >= 2});
      if (m_busy && m_age >= 2) begin
        check_eq("res_data",  {24'd0, bus.res_data}, 32'(m_sum % 256));
        check_eq("res_carry", {31'd0, bus.res_carry}, {31'd0, m_sum >= 256});
        check_eq("res_id",    {31'd0, bus.res_id}, {31'd0, m_id});
      end
      if (m_busy && m_age >= 2 && bus.res_ready) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end else if (w_vld) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = w_id;
        m_prio = !w_id;
        if (w_id) begin
          m_sum = int'(bus.req1_a) + int'(bus.req1_b);
          acc1++;
        end else begin
          m_sum = int'(bus.req0_a) + int'(bus.req0_b);
          acc0++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input bit which, input int budget, input string tag);
    int start;
    bit done;
    start = which ? acc1 : acc0;
    done  = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = which ? (acc1 != start) : (acc0 != start);
    end
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_res(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = bus.res_valid;
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic send(input bit which, input logic [7:0] a, input logic [7:0] b, input string tag);
    if (which) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
    wait_acc(which, 10, tag);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    int tot;
    int p0;
    int p1;
    tests_run = 0; tests_failed = 0;
    acc0 = 0; acc1 = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.res_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Directed sums, including both overflow cases.
    send(1'b0, 8'h12, 8'h34, "acc_12_34");
    wait_res(5, "res_12_34");
    tick();
    send(1'b1, 8'hFF, 8'h02, "acc_ff_02");
    wait_res(5, "res_ff_02");
    tick();
    send(1'b0, 8'h80, 8'h80, "acc_80_80");
    wait_res(5, "res_80_80");
    tick();

    // Contention with operands changing every cycle.
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    tot = acc0 + acc1;
    for (int i = 0; i < 40 && (acc0 + acc1) < tot + 6; i++) begin
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      tick();
    end
    check_eq("contention_count", 32'(acc0 + acc1), 32'(tot + 6));
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick(); tick(); tick();

    // Backpressure with requester 1 waiting.
    bus.res_ready = 1'b0;
    send(1'b0, 8'h5A, 8'hA5, "acc_bp");
    bus.req1_a = 8'h33; bus.req1_b = 8'h44; bus.req1_valid = 1'b1;
    wait_res(5, "res_bp");
    p1 = acc1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("bp_no_grant", 32'(acc1), 32'(p1));
    bus.res_ready = 1'b1;
    wait_acc(1'b1, 3, "bp_release_grant");
    bus.req1_valid = 1'b0;
    wait_res(5, "res_after_bp");
    tick();

    // Reset while in CALC, then while in DONE.
    bus.res_ready = 1'b0;
    send(1'b0, 8'h01, 8'h02, "acc_rst_calc");
    rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
    send(1'b1, 8'h10, 8'h20, "acc_rst_done");
    tick();
    rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    p0 = acc0;
    tick();
    check_eq("post_rst_prio0", 32'(acc0 - p0), 32'd1);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Idle stability with the consumer toggling.
    p0 = acc0; p1 = acc1;
    for (int i = 0; i < 10; i++) begin
      bus.res_ready = 1'($urandom);
      tick();
    end
    check_eq("idle_no_grant", 32'(acc0 + acc1), 32'(p0 + p1));

    // Random traffic: requesters hold valid until accepted.
    for (int i = 0; i < 600; i++) begin
      p0 = acc0; p1 = acc1;
      rst = ($urandom_range(0, 99) == 0);
      bus.res_ready = 1'($urandom);
      if (bus.req0_valid) bus.req0_a = 8'($urandom);
      else if ($urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1; bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      end
      if (bus.req1_valid) bus.req1_b = 8'($urandom);
      else if ($urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1; bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      end
      tick();
      if (acc0 != p0) bus.req0_valid = 1'b0;
      if (acc1 != p1) bus.req1_valid = 1'b0;
    end
    rst = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
